hazard_scoreboard: RTL
======================

Name: hazard_scoreboard

Overview:
- Parametrised successor to the single-cycle load-use detector.
- Tracks every in-flight register write whose result is not yet forwardable: loads, multi-cycle mul/div and variable-latency memory ops.
- Uses a per-register busy bit plus a latency countdown.
- Sits beside the ID stage. Drives the PC/IF_ID stall and ID_EX bubble insertion for RAW and WAW hazards of any latency up to 2**LAT_W-1.

Parameters:
- REG_ADDR_W, 5, register index width; NUM_REGS = 2**REG_ADDR_W entries.
- LAT_W, 3, countdown width; maximum tracked latency 2**LAT_W-1.
- STAT_W, 32, width of statistics counters (used only with the optional feature).

Ports:
- clk_i  input  1  clock, rising edge.
- rst_i  input  1  asynchronous, active-high reset.
- id_valid_i  input  1  instruction in ID is valid.
- id_rs1_i  input  REG_ADDR_W  source 1 index.
- id_rs1_used_i  input  1  instruction reads rs1.
- id_rs2_i  input  REG_ADDR_W  source 2 index.
- id_rs2_used_i  input  1  instruction reads rs2.
- id_rd_i  input  REG_ADDR_W  destination index.
- id_rd_we_i  input  1  instruction writes rd.
- id_lat_i  input  LAT_W  cycles after issue before rd is forwardable; 0 = forwardable next cycle (ALU op).
- flush_i  input  1  branch/trap flush of ID; suppresses issue this cycle.
- wb_valid_i  input  1  early completion of a tracked write (variable-latency memory ack).
- wb_rd_i  input  REG_ADDR_W  register completed by wb_valid_i.
- stall_o  output  1  hold PC and IF_ID, insert bubble into ID_EX.
- busy_o  output  NUM_REGS  current busy vector, bit i = register i pending.

Behaviour:
- State: busy[NUM_REGS-1:0] and cnt[i] (LAT_W bits) per register. rst_i asynchronously clears all busy and cnt. At reset, stall_o = 0 and busy_o = 0.
- Register 0 is never busy. Writes with rd=0 are ignored, and a source index of 0 never stalls.
- stall_o is combinational from current state and ID inputs, zero-latency:
  - stall_o = id_valid_i & !flush_i & (RAW1 | RAW2 | WAW).
  - RAW1 = id_rs1_used_i & busy[id_rs1_i].
  - RAW2 = id_rs2_used_i & busy[id_rs2_i].
  - WAW = id_rd_we_i & busy[id_rd_i].
- Issue occurs when id_valid_i & !stall_o & !flush_i & id_rd_we_i & id_rd_i!=0 & id_lat_i!=0. At that clock edge: busy[id_rd_i] <= 1, cnt[id_rd_i] <= id_lat_i.
- Countdown, every cycle for each busy entry not being issued:
  - cnt != 1: cnt decrements.
  - cnt == 1: entry clears (busy <= 0, cnt <= 0).
- Net timing: an instruction issued in cycle t with latency L makes a dependent in cycle t+k stall for 1 <= k <= L. L=1 gives the classic one-bubble load-use.
- wb_valid_i with wb_rd_i != 0 clears busy[wb_rd_i] and cnt[wb_rd_i] at the next edge, overriding the countdown.
  - Variable-latency ops issue with id_lat_i = max and release via wb_valid_i.
  - wb_valid_i on a non-busy register has no effect.
- Simultaneous issue and wb_valid_i to the same rd cannot occur: a busy rd stalls on WAW. If wb_rd_i targets a register being issued (not busy), issue wins.
- Counter saturation: cnt never wraps. Decrement only when busy and cnt != 0.
- flush_i does not cancel already-issued entries; those instructions are past ID and will complete.
- Reset mid-operation clears all pending entries immediately; stall_o drops in the same cycle.

Optional Feature:
- Macro HAZARD_SCOREBOARD_STATS_EN.
- When defined, adds two outputs:
  - stall_cycles_o (STAT_W): increments every cycle stall_o = 1.
  - hazard_events_o (STAT_W): increments on each rising edge of stall_o, i.e. stall_o = 1 and it was 0 the previous cycle.
- Both counters reset to 0 on rst_i and wrap modulo 2**STAT_W.
- When not defined, these ports and their registers do not exist; all other behaviour is identical.

Test Plan:
- Load-use: issue rd=5, lat=1 in cycle 0; cycle 1 presents rs1=5 used -> stall_o=1 in cycle 1; cycle 2 -> stall_o=0, busy_o[5]=0.
- Multi-cycle: issue rd=7, lat=4 in cycle 0; dependent rs2=7 from cycle 1 -> stall_o=1 for cycles 1..4, 0 in cycle 5. Independent rs1=3 in cycle 2 -> stall_o=0.
- WAW and x0: busy rd=9; issue with rd=9, no sources -> stall_o=1. Issue rd=0, lat=5 -> busy_o stays 0; rs1=0 used never stalls.
- Early release: issue rd=12, lat=7; wb_valid_i with wb_rd_i=12 in cycle 2 -> busy_o[12]=0 in cycle 3; dependent stalls only cycles 1..2.
- Flush/reset: stalled ID with flush_i=1 -> stall_o=0 and no new entry set. Assert rst_i with busy_o=0x0000_1220 -> busy_o=0 and stall_o=0 immediately, without waiting for a clock edge.
- HAZARD_SCOREBOARD_STATS_EN: run the multi-cycle case -> stall_cycles_o=4, hazard_events_o=1. Built without the macro, the same bench minus the stats checks passes unchanged.

Source files
------------

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: per-register busy/countdown scoreboard beside the ID stage.
// Holds PC and IF_ID (and inserts an ID_EX bubble) on RAW or WAW hazards against
// register writes that are still in flight and not yet forwardable.
// Optional feature macro: HAZARD_SCOREBOARD_STATS_EN adds stall statistics outputs.

// One scoreboard entry: busy flag plus a latency countdown for a single register.
module hazard_sb_entry #(
    parameter int LAT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             issue,   // new tracked write to this register
    input  logic [LAT_W-1:0] lat,     // latency loaded on issue
    input  logic             clr,     // early completion (wb ack)
    output logic             busy,
    output logic [LAT_W-1:0] cnt
);

    // Issue has priority over early completion; completion overrides the countdown.
    // The counter only moves while busy and nonzero, so it can never wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= 1'b0;
            cnt  <= '0;
        end else if (issue) begin
            busy <= 1'b1;
            cnt  <= lat;
        end else if (clr) begin
            busy <= 1'b0;
            cnt  <= '0;
        end else if (busy && (cnt != '0)) begin
            if (cnt == LAT_W'(1)) begin
                busy <= 1'b0;
                cnt  <= '0;
            end else begin
                cnt <= cnt - LAT_W'(1);
            end
        end
    end

endmodule

module hazard_scoreboard #(
    parameter int REG_ADDR_W = 5,
    parameter int LAT_W      = 3,
    parameter int STAT_W     = 32,
    localparam int NUM_REGS  = 2 ** REG_ADDR_W
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  id_valid_i,
    input  logic [REG_ADDR_W-1:0] id_rs1_i,
    input  logic                  id_rs1_used_i,
    input  logic [REG_ADDR_W-1:0] id_rs2_i,
    input  logic                  id_rs2_used_i,
    input  logic [REG_ADDR_W-1:0] id_rd_i,
    input  logic                  id_rd_we_i,
    input  logic [LAT_W-1:0]      id_lat_i,
    input  logic                  flush_i,
    input  logic                  wb_valid_i,
    input  logic [REG_ADDR_W-1:0] wb_rd_i,
    output logic                  stall_o,
    output logic [NUM_REGS-1:0]   busy_o
`ifdef HAZARD_SCOREBOARD_STATS_EN
    ,
    output logic [STAT_W-1:0]     stall_cycles_o,
    output logic [STAT_W-1:0]     hazard_events_o
`endif
);

    logic [NUM_REGS-1:0] busy;
    logic [NUM_REGS-1:0] issue_vec;
    logic [NUM_REGS-1:0] clr_vec;
    logic                raw1;
    logic                raw2;
    logic                waw;
    logic                issue;

    // Hazard detection is purely combinational so the stall lands in the same
    // cycle the dependent instruction sits in ID. busy[0] is tied low, so x0
    // as a source or destination never stalls.
    always_comb begin
        raw1    = id_rs1_used_i & busy[id_rs1_i];
        raw2    = id_rs2_used_i & busy[id_rs2_i];
        waw     = id_rd_we_i & busy[id_rd_i];
        stall_o = id_valid_i & ~flush_i & (raw1 | raw2 | waw);
        // Latency 0 results forward next cycle and never need tracking.
        issue   = id_valid_i & ~stall_o & ~flush_i & id_rd_we_i &
                  (id_rd_i != '0) & (id_lat_i != '0);
    end

    assign busy[0]      = 1'b0;
    assign issue_vec[0] = 1'b0;
    assign clr_vec[0]   = 1'b0;

    genvar gi;
    generate
        for (gi = 1; gi < NUM_REGS; gi++) begin : g_ent
            logic [LAT_W-1:0] cnt;

            assign issue_vec[gi] = issue & (id_rd_i == REG_ADDR_W'(gi));
            assign clr_vec[gi]   = wb_valid_i & (wb_rd_i == REG_ADDR_W'(gi));

            hazard_sb_entry #(
                .LAT_W (LAT_W)
            ) u_ent (
                .clk   (clk_i),
                .rst   (rst_i),
                .issue (issue_vec[gi]),
                .lat   (id_lat_i),
                .clr   (clr_vec[gi]),
                .busy  (busy[gi]),
                .cnt   (cnt)
            );
        end
    endgenerate

    assign busy_o = busy;

`ifdef HAZARD_SCOREBOARD_STATS_EN
    logic stall_q;

    // Stall statistics: total stalled cycles and number of distinct stall episodes
    // (a stall cycle whose predecessor was not stalled). Both wrap naturally.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_q         <= 1'b0;
            stall_cycles_o  <= '0;
            hazard_events_o <= '0;
        end else begin
            stall_q <= stall_o;
            if (stall_o)
                stall_cycles_o <= stall_cycles_o + STAT_W'(1);
            if (stall_o && !stall_q)
                hazard_events_o <= hazard_events_o + STAT_W'(1);
        end
    end
`endif

endmodule
